// File: rtl/interrupt_sequencer_pkg.sv
// mos6502_pkg: interrupt source/state types and default vector addresses
// shared by the 6502 interrupt path.
package mos6502_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    IRQ   = 2'b01,
    NMI   = 2'b10,
    RESET = 2'b11
  } int_src_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    LOAD     = 3'd4
  } int_state_t;

  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

  function automatic logic [15:0] vec_base(
    input int_src_t    src,
    input logic [15:0] nmi,
    input logic [15:0] rst,
    input logic [15:0] irq
  );
    logic [15:0] b;
    b = irq;
    unique case (1'b1)
      (src == NMI):   b = nmi;
      (src == RESET): b = rst;
      default:        b = irq;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: decoder handshake and vector-fetch bus.
// master = sequencer side, slave = decoder/memory side.
interface interrupt_sequencer_if;

  logic        BRK;
  logic        I_FLAG;
  logic        INSN_DONE;
  logic        RDY;
  logic        INT_ACK;
  logic [7:0]  DATA_IN;
  logic        INT_REQ;
  logic [1:0]  INT_SRC;
  logic        B_FLAG;
  logic        VEC_VALID;
  logic [15:0] VEC_ADDR;
  logic        PC_LOAD;
  logic [15:0] PC_TARGET;
  logic        SET_I;

  modport master (
    input  BRK, I_FLAG, INSN_DONE, RDY, INT_ACK, DATA_IN,
    output INT_REQ, INT_SRC, B_FLAG, VEC_VALID, VEC_ADDR,
    output PC_LOAD, PC_TARGET, SET_I
  );

  modport slave (
    output BRK, I_FLAG, INSN_DONE, RDY, INT_ACK, DATA_IN,
    input  INT_REQ, INT_SRC, B_FLAG, VEC_VALID, VEC_ADDR,
    input  PC_LOAD, PC_TARGET, SET_I
  );

endinterface

// File: rtl/interrupt_sequencer_sync_edge.sv
// sync_edge: DEPTH-flop synchronizer with a registered falling-edge
// strobe; reset value is the pin's inactive level.
module sync_edge #(
  parameter int   DEPTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;
  logic             last_q;
  logic             fall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {DEPTH{RST_VAL}};
      last_q <= RST_VAL;
      fall_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      last_q <= sync_q[DEPTH-1];
      fall_q <= last_q & ~sync_q[DEPTH-1];
    end
  end

  assign level_o = sync_q[DEPTH-1];
  assign fall_o  = fall_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: RESET/NMI/IRQ/BRK arbitration and vector fetch.
// Define INT_SYNC2_EN for two-flop pin synchronizers (one flop otherwise).
module interrupt_sequencer
  import mos6502_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IRQ_N,
  input  logic                  NMI_N,
  interrupt_sequencer_if.master bus
);

`ifdef INT_SYNC2_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_REQ      = REQ;
  localparam logic [2:0] S_FETCH_LO = FETCH_LO;
  localparam logic [2:0] S_FETCH_HI = FETCH_HI;
  localparam logic [2:0] S_LOAD     = LOAD;

  logic [2:0]  state_q, state_d;
  int_src_t    src_q, src_d, src_eff;
  logic        b_q, b_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        brk_pend_q, brk_pend_d;
  logic [15:0] pc_q, pc_d;
  logic        int_req_q;
  logic        pc_load_q;
  logic        set_i_q;

  logic        irq_lvl;
  logic        nmi_fall;
  logic        irq_act;
  logic [15:0] base;

  sync_edge #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_nmi_sync (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .d_i     (NMI_N),
    .level_o (),
    .fall_o  (nmi_fall)
  );

  sync_edge #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_irq_sync (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .d_i     (IRQ_N),
    .level_o (irq_lvl),
    .fall_o  ()
  );

  assign irq_act = ~irq_lvl & ~bus.I_FLAG;

  // An NMI that lands while REQ is open takes over the request.
  assign src_eff = nmi_pend_q ? NMI : src_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    b_d        = b_q;
    nmi_pend_d = nmi_pend_q | nmi_fall;
    brk_pend_d = brk_pend_q | bus.BRK;
    pc_d       = pc_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.INSN_DONE && (nmi_pend_q || brk_pend_q || irq_act)) begin
          state_d = S_REQ;
          src_d   = nmi_pend_q ? NMI : IRQ;
          b_d     = !nmi_pend_q && brk_pend_q;
        end
      end
      (state_q == S_REQ): begin
        src_d = src_eff;
        if (bus.INT_ACK) begin
          state_d = S_FETCH_LO;
          if (src_eff == NMI) nmi_pend_d = nmi_fall;
          if (b_q)            brk_pend_d = bus.BRK;
        end
      end
      (state_q == S_FETCH_LO): begin
        if (bus.RDY) begin
          pc_d[7:0] = bus.DATA_IN;
          state_d   = S_FETCH_HI;
        end
      end
      (state_q == S_FETCH_HI): begin
        if (bus.RDY) begin
          pc_d[15:8] = bus.DATA_IN;
          state_d    = S_LOAD;
        end
      end
      (state_q == S_LOAD): begin
        state_d = S_IDLE;
        src_d   = NONE;
        b_d     = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_FETCH_LO;
      src_q      <= RESET;
      b_q        <= 1'b0;
      nmi_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      pc_q       <= 16'h0000;
      int_req_q  <= 1'b0;
      pc_load_q  <= 1'b0;
      set_i_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      b_q        <= b_d;
      nmi_pend_q <= nmi_pend_d;
      brk_pend_q <= brk_pend_d;
      pc_q       <= pc_d;
      int_req_q  <= (state_d == S_REQ);
      pc_load_q  <= (state_d == S_LOAD);
      set_i_q    <= (state_d == S_LOAD);
    end
  end

  assign base = vec_base(src_q, VEC_NMI, VEC_RST, VEC_IRQ);

  assign bus.VEC_VALID = (state_q == S_FETCH_LO) ||
                         (state_q == S_FETCH_HI);
  assign bus.VEC_ADDR  = base + {15'd0, state_q == S_FETCH_HI};
  assign bus.INT_REQ   = int_req_q;
  assign bus.INT_SRC   = src_q;
  assign bus.B_FLAG    = b_q;
  assign bus.PC_LOAD   = pc_load_q;
  assign bus.PC_TARGET = pc_q;
  assign bus.SET_I     = set_i_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed steps with a vector scoreboard
// popped on every PC_LOAD pulse.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  src;
    logic        b;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  logic IRQ_N;
  logic NMI_N;

  interrupt_sequencer_if bus ();

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  interrupt_sequencer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .IRQ_N (IRQ_N),
    .NMI_N (NMI_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Vector ROM: NMI=A000, RESET=1234, IRQ/BRK=C0DE.
  always_comb begin
    case (bus.VEC_ADDR)
      16'hFFFA: bus.DATA_IN = 8'h00;
      16'hFFFB: bus.DATA_IN = 8'hA0;
      16'hFFFC: bus.DATA_IN = 8'h34;
      16'hFFFD: bus.DATA_IN = 8'h12;
      16'hFFFE: bus.DATA_IN = 8'hDE;
      16'hFFFF: bus.DATA_IN = 8'hC0;
      default:  bus.DATA_IN = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
  endtask

  task automatic wait_load(input int max, output int n);
    n = 0;
    while (bus.PC_LOAD !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    while (bus.INT_REQ !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic check_load(input string tag);
    exp_t e;
    chk({tag, "_pcl"}, {31'd0, bus.PC_LOAD}, 32'd1);
    chk({tag, "_seti"}, {31'd0, bus.SET_I}, 32'd1);
    chk({tag, "_sbq"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_pct"}, {16'd0, bus.PC_TARGET}, {16'd0, e.pc});
      chk({tag, "_src"}, {30'd0, bus.INT_SRC}, {30'd0, e.src});
      chk({tag, "_b"}, {31'd0, bus.B_FLAG}, {31'd0, e.b});
    end
  endtask

  task automatic pulse_brk_req();
    bus.BRK = 1'b1;
    tick();
    bus.BRK = 1'b0;
    bus.INSN_DONE = 1'b1;
    tick();
    bus.INSN_DONE = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    RST_N         = 1'b0;
    IRQ_N         = 1'b1;
    NMI_N         = 1'b1;
    bus.BRK       = 1'b0;
    bus.I_FLAG    = 1'b1;
    bus.INSN_DONE = 1'b0;
    bus.RDY       = 1'b1;
    bus.INT_ACK   = 1'b0;

    // Reset fetch
    repeat (3) tick();
    chk("rst_valid", {31'd0, bus.VEC_VALID}, 32'd1);
    chk("rst_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFC);
    chk("rst_src", {30'd0, bus.INT_SRC}, 32'd3);
    chk("rst_b", {31'd0, bus.B_FLAG}, 32'd0);
    chk("rst_pcl", {31'd0, bus.PC_LOAD}, 32'd0);
    chk("rst_seti", {31'd0, bus.SET_I}, 32'd0);
    chk("rst_req", {31'd0, bus.INT_REQ}, 32'd0);
    chk("rst_pct", {16'd0, bus.PC_TARGET}, 32'd0);
    sb.push_back('{16'h1234, 2'b11, 1'b0});
    RST_N = 1'b1;
    wait_load(8, n);
    chk("rst_lat", n, 2);
    check_load("rst");
    tick();
    chk("idle_src", {30'd0, bus.INT_SRC}, 32'd0);
    chk("idle_pcl", {31'd0, bus.PC_LOAD}, 32'd0);
    ack();
    chk("ack_ignored", {31'd0, bus.VEC_VALID}, 32'd0);
    chk("ack_ign_req", {31'd0, bus.INT_REQ}, 32'd0);

    // IRQ masked, then unmasked
    IRQ_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.INSN_DONE = 1'b1;
      tick();
      bus.INSN_DONE = 1'b0;
      chk("irq_masked", {31'd0, bus.INT_REQ}, 32'd0);
    end
    bus.I_FLAG    = 1'b0;
    bus.INSN_DONE = 1'b1;
    tick();
    bus.INSN_DONE = 1'b0;
    chk("irq_req", {31'd0, bus.INT_REQ}, 32'd1);
    chk("irq_src", {30'd0, bus.INT_SRC}, 32'd1);
    chk("irq_b", {31'd0, bus.B_FLAG}, 32'd0);
    sb.push_back('{16'hC0DE, 2'b01, 1'b0});
    tick();
    chk("irq_req_hold", {31'd0, bus.INT_REQ}, 32'd1);
    ack();
    bus.I_FLAG = 1'b1;
    chk("irq_lo_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFE);
    chk("irq_req_drop", {31'd0, bus.INT_REQ}, 32'd0);
    tick();
    chk("irq_hi_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFF);
    tick();
    check_load("irq");
    IRQ_N = 1'b0;
    IRQ_N = 1'b1;
    repeat (2) tick();

    // NMI held low: one service only
    NMI_N = 1'b0;
    bus.INSN_DONE = 1'b1;
    wait_req(10, n);
    chk("nmi_req", {31'd0, bus.INT_REQ}, 32'd1);
    chk("nmi_src", {30'd0, bus.INT_SRC}, 32'd2);
    chk("nmi_b", {31'd0, bus.B_FLAG}, 32'd0);
    sb.push_back('{16'hA000, 2'b10, 1'b0});
    ack();
    chk("nmi_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFA);
    wait_load(6, n);
    chk("nmi_lat", n, 2);
    check_load("nmi");
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.INT_REQ === 1'b1) cnt++;
    end
    chk("nmi_once", cnt, 0);
    bus.INSN_DONE = 1'b0;
    NMI_N = 1'b1;
    repeat (3) tick();

    // BRK hijacked by NMI
    pulse_brk_req();
    chk("hj_req", {31'd0, bus.INT_REQ}, 32'd1);
    chk("hj_src", {30'd0, bus.INT_SRC}, 32'd1);
    chk("hj_b", {31'd0, bus.B_FLAG}, 32'd1);
    NMI_N = 1'b0;
    repeat (6) tick();
    chk("hj_up_src", {30'd0, bus.INT_SRC}, 32'd2);
    chk("hj_up_b", {31'd0, bus.B_FLAG}, 32'd1);
    chk("hj_up_req", {31'd0, bus.INT_REQ}, 32'd1);
    sb.push_back('{16'hA000, 2'b10, 1'b1});
    ack();
    chk("hj_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFA);
    chk("hj_valid", {31'd0, bus.VEC_VALID}, 32'd1);
    wait_load(6, n);
    chk("hj_lat", n, 2);
    check_load("hj");
    NMI_N = 1'b1;
    tick();
    bus.INSN_DONE = 1'b1;
    tick();
    bus.INSN_DONE = 1'b0;
    chk("hj_cleared", {31'd0, bus.INT_REQ}, 32'd0);
    repeat (2) tick();

    // RDY stall in FETCH_HI
    pulse_brk_req();
    chk("st_src", {30'd0, bus.INT_SRC}, 32'd1);
    chk("st_b", {31'd0, bus.B_FLAG}, 32'd1);
    sb.push_back('{16'hC0DE, 2'b01, 1'b1});
    ack();
    tick();
    chk("st_hi_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFF);
    bus.RDY = 1'b0;
    repeat (4) tick();
    chk("st_hold_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFF);
    chk("st_hold_pcl", {31'd0, bus.PC_LOAD}, 32'd0);
    bus.RDY = 1'b1;
    wait_load(6, n);
    chk("st_lat", n, 1);
    check_load("st");
    repeat (2) tick();

    // Reset during an IRQ fetch with BRK and NMI pending
    bus.I_FLAG = 1'b0;
    IRQ_N = 1'b0;
    repeat (3) tick();
    bus.INSN_DONE = 1'b1;
    tick();
    bus.INSN_DONE = 1'b0;
    chk("rm_req", {31'd0, bus.INT_REQ}, 32'd1);
    chk("rm_src", {30'd0, bus.INT_SRC}, 32'd1);
    bus.BRK = 1'b1;
    tick();
    bus.BRK = 1'b0;
    bus.RDY = 1'b0;
    NMI_N = 1'b0;
    ack();
    chk("rm_lo_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFE);
    repeat (5) tick();
    chk("rm_stall_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFE);
    RST_N = 1'b0;
    IRQ_N = 1'b1;
    NMI_N = 1'b1;
    bus.I_FLAG = 1'b1;
    bus.RDY = 1'b1;
    repeat (2) tick();
    chk("rm_rst_addr", {16'd0, bus.VEC_ADDR}, 32'hFFFC);
    chk("rm_rst_src", {30'd0, bus.INT_SRC}, 32'd3);
    chk("rm_rst_pct", {16'd0, bus.PC_TARGET}, 32'd0);
    sb.push_back('{16'h1234, 2'b11, 1'b0});
    RST_N = 1'b1;
    wait_load(8, n);
    chk("rm_lat", n, 2);
    check_load("rm");
    tick();
    bus.INSN_DONE = 1'b1;
    tick();
    bus.INSN_DONE = 1'b0;
    chk("rm_pend_clr", {31'd0, bus.INT_REQ}, 32'd0);
    tick();
    chk("rm_pend_clr2", {31'd0, bus.INT_REQ}, 32'd0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Upstream companion of the 6502 core's instruction decoder. It arbitrates the RESET, NMI, IRQ and BRK sources, raises a request at an instruction boundary, and on acknowledge fetches the 16-bit vector from memory itself. It then hands the decoder a program-counter load with the I-flag set request.

## Interface
- Parameters
  - VEC_NMI, 16'hFFFA: NMI vector base address.
  - VEC_RST, 16'hFFFC: reset vector base address.
  - VEC_IRQ, 16'hFFFE: IRQ/BRK vector base address.
- Ports
  - CLK  in  1  single clock; all state changes on its rising edge.
  - RST_N  in  1  reset, synchronous and active-low.
  - IRQ_N  in  1  maskable interrupt, level, active-low, asynchronous.
  - NMI_N  in  1  non-maskable interrupt, falling-edge, asynchronous.
  - BRK  in  1  one-cycle pulse from the decoder when a BRK opcode executes.
  - I_FLAG  in  1  interrupt-disable bit of the processor status.
  - INSN_DONE  in  1  instruction boundary (SYNC) from the decoder.
  - RDY  in  1  bus ready; when low, the vector fetch stalls.
  - INT_ACK  in  1  decoder has finished pushing PC/P; single-cycle pulse.
  - DATA_IN  in  8  memory read data.
  - INT_REQ  out  1  request to the decoder.
  - INT_SRC  out  2  00 none, 01 IRQ/BRK, 10 NMI, 11 RESET.
  - B_FLAG  out  1  source is BRK; valid while INT_SRC≠00.
  - VEC_VALID  out  1  this block owns the address bus, read cycle.
  - VEC_ADDR  out  16  vector byte address.
  - PC_LOAD  out  1  one-cycle pulse carrying PC_TARGET.
  - PC_TARGET  out  16  fetched vector, held until the next fetch.
  - SET_I  out  1  one-cycle pulse coincident with PC_LOAD.

## Operation
- FSM states: IDLE, REQ, FETCH_LO, FETCH_HI, LOAD.
- While RST_N=0:
  - State is FETCH_LO, INT_SRC=11, B_FLAG=0.
  - nmi_pend=0, brk_pend=0, PC_TARGET=0.
  - All pulses 0.
  - VEC_VALID=1, VEC_ADDR=VEC_RST.
- Pending sources:
  - nmi_pend sets on a synchronized 1→0 transition of NMI_N.
  - brk_pend sets on BRK.
  - irq_act = synchronized IRQ_N low AND !I_FLAG. It is a live level and is not latched.
- IDLE → REQ on INSN_DONE when nmi_pend|brk_pend|irq_act.
  - On this transition INT_SRC is latched: NMI (10) > BRK/IRQ (01).
  - B_FLAG=1 only if brk_pend (BRK wins over IRQ in the 01 class).
- REQ: INT_REQ=1.
  - A new NMI edge while in REQ upgrades INT_SRC to 10 and keeps B_FLAG unchanged (BRK hijack).
  - On INT_ACK → FETCH_LO. The committed source's pending bit is cleared in the same cycle.
  - IRQ is never cleared (it is a level).
- FETCH_LO:
  - VEC_VALID=1, VEC_ADDR=base.
  - When RDY=1: capture DATA_IN into PC_TARGET[7:0] → FETCH_HI.
  - When RDY=0: hold.
- FETCH_HI:
  - VEC_ADDR=base+1.
  - When RDY=1: capture PC_TARGET[15:8] → LOAD.
- LOAD: PC_LOAD=1, SET_I=1 → IDLE. INT_SRC returns to 00.
- base: 10→VEC_NMI, 11→VEC_RST, 01→VEC_IRQ.
- Boundaries:
  - An NMI edge arriving during FETCH or LOAD stays pending and is serviced at the next INSN_DONE.
  - BRK arriving while not IDLE: brk_pend holds.
  - An IRQ deasserted before INSN_DONE is lost, matching 6502 behaviour.
  - RST_N low in any state aborts and re-enters the reset fetch.
  - INT_ACK outside REQ is ignored.

## Timing
- Synchronizer depth S: 2 with the macro, 1 without.
  - nmi_pend is set S+1 edges after the first edge that samples NMI_N low.
  - irq_act is valid S edges after IRQ_N falls.
- INT_REQ rises on the edge sampling INSN_DONE with a source pending.
- INT_ACK→PC_LOAD is 3 cycles with RDY=1: FETCH_LO, FETCH_HI, LOAD. Each RDY=0 cycle adds one.
- After RST_N rises, PC_LOAD pulses 2 cycles later with RDY=1, since FETCH_LO is already active during reset.
- All outputs are registered except VEC_ADDR and VEC_VALID, which decode from the state register.

## Configuration
- INT_SYNC2_EN defined: two-flop synchronizers on IRQ_N and NMI_N.
- INT_SYNC2_EN undefined: one flop each, one cycle less latency. Use this only when the pins are already synchronous to CLK.

## Structure
- Shared package `mos6502_pkg`:
  - int_src_t enum (NONE, IRQ, NMI, RESET).
  - int_state_t enum for the FSM.
  - Vector address localparams.
- One sub-module `sync_edge`: parameterized-depth synchronizer with a registered falling-edge output. It is instantiated for NMI_N, and for IRQ_N using the level output only.

## Test plan
- Reset: RST_N low 3 cycles, DATA_IN=34 at FFFC and 12 at FFFD, RDY=1 → PC_LOAD with PC_TARGET=16'h1234, INT_SRC=11, SET_I=1.
- IRQ mask: IRQ_N low with I_FLAG=1, INSN_DONE pulses → INT_REQ stays 0. Clear I_FLAG → INT_REQ at the next INSN_DONE, INT_SRC=01, fetch from FFFE/FFFF.
- NMI edge: NMI_N falls once and is held low 20 cycles → exactly one service from FFFA; no second INT_REQ.
- Hijack: BRK pulse, INSN_DONE, then an NMI edge before INT_ACK → VEC_ADDR=FFFA, B_FLAG=1.
- RDY stall: RDY=0 for 4 cycles in FETCH_HI → PC_LOAD delayed by 4, PC_TARGET correct.
- Reset mid-fetch: RST_N low during FETCH_LO of an IRQ → nmi_pend/brk_pend cleared, the next PC_LOAD carries the FFFC vector.
